alu_issue_ctrl: RTL and testbench

Issue controller between the ID and EX stages of the pipelined MIPS core. It decodes the ID-stage instruction into the 3-bit ALU operation code and its EX-stage control bits, then registers them into the EX stage. It inserts a bubble on a load-use hazard and flushes ID when a `beq` in EX is taken, as reported by the ALU's `branch_eval`. It also keeps a saturating bubble counter for performance analysis.

---
 rtl/alu_issue_ctrl_if.sv | 42 ++++
 rtl/alu_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// ID/EX issue bus: decoded-instruction inputs from ID, registered EX controls and status out.
interface alu_issue_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [5:0]       id_funct;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             branch_eval;

    logic             ex_valid;
    logic [2:0]       ex_what_to_do;
    logic             ex_use_imm;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_is_branch;
    logic [4:0]       ex_dst;
    logic             stall;
    logic             flush;
    logic             illegal_op;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] bubble_cnt;

    // Pipeline side: drives ID and the branch result, observes EX.
    modport master (
        output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, branch_eval,
        input  ex_valid, ex_what_to_do, ex_use_imm, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_is_branch, ex_dst, stall, flush, illegal_op,
               ctrl_state, bubble_cnt
    );

    // Issue controller side.
    modport slave (
        input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, branch_eval,
        output ex_valid, ex_what_to_do, ex_use_imm, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_is_branch, ex_dst, stall, flush, illegal_op,
               ctrl_state, bubble_cnt
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ID->EX issue controller: decodes the ID instruction, registers it into EX, and inserts
// bubbles for load-use hazards and taken branches. CNT_W must match the interface's CNT_W.
module alu_issue_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] what_to_do;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       is_branch;
        logic [4:0] dst;
    } ex_t;

    state_e           state_q;
    ex_t              ex_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    ex_t  dec_ex;
    logic dec_legal;
    logic dec_wr;
    logic use_rs;
    logic use_rt;
    logic hazard;
    logic flush;
    logic stall;

    // Decode the ID instruction into EX controls and register-use flags.
    always_comb begin
        dec_ex     = '0;
        dec_legal  = 1'b1;
        dec_wr     = 1'b0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        case (bus.id_opcode)
            6'h00: begin
                dec_wr     = 1'b1;
                dec_ex.dst = bus.id_rd;
                case (bus.id_funct)
                    6'h20: begin
                        dec_ex.what_to_do = 3'b000;
                        use_rs            = 1'b1;
                        use_rt            = 1'b1;
                    end
                    6'h00: begin
                        dec_ex.what_to_do = 3'b010;
                        use_rt            = 1'b1;
                    end
                    6'h2A: begin
                        dec_ex.what_to_do = 3'b011;
                        use_rs            = 1'b1;
                        use_rt            = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin
                dec_ex.what_to_do = 3'b001;
                dec_ex.use_imm    = 1'b1;
                dec_wr            = 1'b1;
                dec_ex.dst        = bus.id_rt;
                use_rs            = 1'b1;
            end
            6'h23: begin
                dec_ex.what_to_do = 3'b101;
                dec_ex.use_imm    = 1'b1;
                dec_ex.mem_read   = 1'b1;
                dec_wr            = 1'b1;
                dec_ex.dst        = bus.id_rt;
                use_rs            = 1'b1;
            end
            6'h2B: begin
                dec_ex.what_to_do = 3'b100;
                dec_ex.use_imm    = 1'b1;
                dec_ex.mem_write  = 1'b1;
                use_rs            = 1'b1;
                use_rt            = 1'b1;
            end
            6'h04: begin
                dec_ex.what_to_do = 3'b000;
                dec_ex.is_branch  = 1'b1;
                use_rs            = 1'b1;
                use_rt            = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_ex = '0;
            dec_wr = 1'b0;
            use_rs = 1'b0;
            use_rt = 1'b0;
        end
        // Writes to r0 are dropped at decode.
        dec_ex.reg_write = dec_wr & (dec_ex.dst != 5'd0);
        dec_ex.valid     = 1'b1;
    end

    // Hazard and branch-flush detection against the instruction currently in EX.
    always_comb begin
        hazard = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.dst != 5'd0) &
                 ((use_rs & (bus.id_rs == ex_q.dst)) | (use_rt & (bus.id_rt == ex_q.dst)));
        flush  = ex_q.valid & ex_q.is_branch & bus.branch_eval;
        stall  = hazard & ~flush;
    end

    // Issue FSM: EX register, illegal pulse, state and saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
            state_q   <= StRun;
            cnt_q     <= '0;
        end else begin
            illegal_q <= 1'b0;
            if (flush) begin
                ex_q    <= '0;
                state_q <= StFlush;
            end else if (stall) begin
                ex_q    <= '0;
                state_q <= StStall;
            end else if (bus.id_valid && !dec_legal) begin
                ex_q      <= '0;
                illegal_q <= 1'b1;
                state_q   <= StRun;
            end else if (!bus.id_valid) begin
                ex_q    <= '0;
                state_q <= StRun;
            end else begin
                ex_q    <= dec_ex;
                state_q <= StRun;
            end
            if ((flush || stall) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_what_to_do = ex_q.what_to_do;
    assign bus.ex_use_imm    = ex_q.use_imm;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_is_branch  = ex_q.is_branch;
    assign bus.ex_dst        = ex_q.dst;
    assign bus.stall         = stall;
    assign bus.flush         = flush;
    assign bus.illegal_op    = illegal_q;
    assign bus.ctrl_state    = state_q;
    assign bus.bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios then random traffic, all checked against
// an instruction-level reference model.
module tb_alu_issue_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_BAD = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SLL = 6'h00, FN_SLT = 6'h2A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

    alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [2:0] what;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       is_branch;
        logic [4:0] dst;
    } ex_t;

    typedef struct packed {
        logic legal;
        logic use_rs;
        logic use_rt;
        ex_t  ex;
    } dec_t;

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what EX should hold after each edge.
    ex_t  m_ex;
    logic m_ill;
    int   m_state;
    int   m_cnt;
    logic seen_stall;
    logic seen_flush;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction semantics straight from the decode table.
    function automatic dec_t decode(input ins_t i);
        dec_t d;
        logic wr;
        d = '0;
        wr = 1'b0;
        d.legal = 1'b1;
        if (i.op == OP_R && i.fn == FN_ADD) begin
            d.ex.what = 3'd0; wr = 1; d.ex.dst = i.rd; d.use_rs = 1; d.use_rt = 1;
        end else if (i.op == OP_R && i.fn == FN_SLL) begin
            d.ex.what = 3'd2; wr = 1; d.ex.dst = i.rd; d.use_rt = 1;
        end else if (i.op == OP_R && i.fn == FN_SLT) begin
            d.ex.what = 3'd3; wr = 1; d.ex.dst = i.rd; d.use_rs = 1; d.use_rt = 1;
        end else if (i.op == OP_ADDI) begin
            d.ex.what = 3'd1; d.ex.use_imm = 1; wr = 1; d.ex.dst = i.rt; d.use_rs = 1;
        end else if (i.op == OP_LW) begin
            d.ex.what = 3'd5; d.ex.use_imm = 1; wr = 1; d.ex.dst = i.rt; d.use_rs = 1;
            d.ex.mem_read = 1;
        end else if (i.op == OP_SW) begin
            d.ex.what = 3'd4; d.ex.use_imm = 1; d.use_rs = 1; d.use_rt = 1;
            d.ex.mem_write = 1;
        end else if (i.op == OP_BEQ) begin
            d.ex.what = 3'd0; d.ex.is_branch = 1; d.use_rs = 1; d.use_rt = 1;
        end else begin
            d.legal = 1'b0;
        end
        d.ex.reg_write = wr && (d.ex.dst != 0);
        d.ex.valid = 1'b1;
        return d;
    endfunction

    function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ins_t i;
        i.v = 1'b1; i.op = op; i.fn = fn; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i = mk(OP_R, FN_ADD, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)));
        case ($urandom_range(0, 7))
            0: i.fn = FN_ADD;
            1: i.fn = FN_SLL;
            2: i.fn = FN_SLT;
            3: i.op = OP_ADDI;
            4: i.op = OP_LW;
            5: i.op = OP_SW;
            6: i.op = OP_BEQ;
            default: if ($urandom_range(0, 1) == 1) i.op = OP_BAD; else i.fn = 6'h3F;
        endcase
        i.v = ($urandom_range(0, 9) != 0);
        return i;
    endfunction

    task automatic model_reset();
        m_ex = '0; m_ill = 1'b0; m_state = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(bus.ex_valid), 32'(m_ex.valid));
        check_val({tag, "_what"}, 32'(bus.ex_what_to_do), 32'(m_ex.what));
        check_val({tag, "_imm"}, 32'(bus.ex_use_imm), 32'(m_ex.use_imm));
        check_val({tag, "_rw"}, 32'(bus.ex_reg_write), 32'(m_ex.reg_write));
        check_val({tag, "_mr"}, 32'(bus.ex_mem_read), 32'(m_ex.mem_read));
        check_val({tag, "_mw"}, 32'(bus.ex_mem_write), 32'(m_ex.mem_write));
        check_val({tag, "_br"}, 32'(bus.ex_is_branch), 32'(m_ex.is_branch));
        check_val({tag, "_dst"}, 32'(bus.ex_dst), 32'(m_ex.dst));
        check_val({tag, "_ill"}, 32'(bus.illegal_op), 32'(m_ill));
        check_val({tag, "_state"}, 32'(bus.ctrl_state), 32'(m_state));
        check_val({tag, "_cnt"}, 32'(bus.bubble_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input ins_t i, input logic be);
        bus.id_valid = i.v; bus.id_opcode = i.op; bus.id_funct = i.fn;
        bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd; bus.branch_eval = be;
    endtask

    // One cycle: drive ID, check stall/flush, clock, then check EX against the model.
    task automatic step(input string tag, input ins_t i, input logic be);
        dec_t d;
        logic hz, fl, st;
        @(negedge clk);
        drive(i, be);
        #1;
        d  = decode(i);
        fl = m_ex.valid && m_ex.is_branch && be;
        hz = i.v && d.legal && m_ex.valid && m_ex.mem_read && (m_ex.dst != 0) &&
             ((d.use_rs && i.rs == m_ex.dst) || (d.use_rt && i.rt == m_ex.dst));
        st = hz && !fl;
        check_val({tag, "_stall"}, 32'(bus.stall), 32'(st));
        check_val({tag, "_flush"}, 32'(bus.flush), 32'(fl));
        seen_stall = bus.stall;
        seen_flush = bus.flush;
        m_ill = 1'b0;
        if (fl || st) begin
            m_ex = '0;
            m_state = fl ? 2 : 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_state = 0;
            m_ex = (i.v && d.legal) ? d.ex : '0;
            m_ill = i.v && !d.legal;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        ins_t cur;
        model_reset();
        drive(mk(OP_R, FN_ADD, 0, 0, 0), 1'b0);
        bus.id_valid = 1'b0;
        #1;
        check_outputs("reset");
        check_val("reset_stall", 32'(bus.stall), 32'd0);
        check_val("reset_flush", 32'(bus.flush), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic issue.
        step("add", mk(OP_R, FN_ADD, 1, 2, 3), 1'b0);
        check_val("add_dst", 32'(bus.ex_dst), 32'd3);
        check_val("add_rw", 32'(bus.ex_reg_write), 32'd1);

        // Load-use: one bubble, then the held add issues.
        step("lw", mk(OP_LW, 0, 1, 5, 0), 1'b0);
        step("lu_hold", mk(OP_R, FN_ADD, 5, 2, 4), 1'b0);
        check_val("lu_stall", 32'(seen_stall), 32'd1);
        check_val("lu_state", 32'(bus.ctrl_state), 32'd1);
        step("lu_issue", mk(OP_R, FN_ADD, 5, 2, 4), 1'b0);
        check_val("lu_issued", 32'(bus.ex_valid), 32'd1);
        check_val("lu_cnt", 32'(bus.bubble_cnt), 32'd1);

        // sll ignores rs; lw to r0 never hazards.
        step("lw2", mk(OP_LW, 0, 1, 5, 0), 1'b0);
        step("sll", mk(OP_R, FN_SLL, 5, 6, 7), 1'b0);
        check_val("sll_nostall", 32'(seen_stall), 32'd0);
        step("lw0", mk(OP_LW, 0, 1, 0, 0), 1'b0);
        step("r0add", mk(OP_R, FN_ADD, 0, 2, 3), 1'b0);
        check_val("r0_nostall", 32'(seen_stall), 32'd0);

        // Taken and not-taken beq.
        step("beq", mk(OP_BEQ, 0, 1, 2, 0), 1'b0);
        step("taken", mk(OP_R, FN_ADD, 1, 2, 3), 1'b1);
        check_val("beq_flush", 32'(seen_flush), 32'd1);
        check_val("beq_state", 32'(bus.ctrl_state), 32'd2);
        step("beq2", mk(OP_BEQ, 0, 1, 2, 0), 1'b0);
        step("ntaken", mk(OP_ADDI, 0, 1, 9, 0), 1'b0);
        check_val("nt_flush", 32'(seen_flush), 32'd0);
        check_val("nt_issue", 32'(bus.ex_valid), 32'd1);

        // Taken branch with a would-be dependent in ID: flush only, one count.
        step("beq3", mk(OP_BEQ, 0, 5, 5, 0), 1'b0);
        step("coinc", mk(OP_R, FN_ADD, 5, 5, 6), 1'b1);
        check_val("coinc_stall", 32'(seen_stall), 32'd0);
        check_val("coinc_flush", 32'(seen_flush), 32'd1);

        // Illegal opcode pulses once.
        step("ill", mk(OP_BAD, 0, 1, 2, 3), 1'b0);
        check_val("ill_pulse", 32'(bus.illegal_op), 32'd1);
        step("ill_after", mk(OP_R, FN_ADD, 1, 2, 3), 1'b0);
        check_val("ill_clear", 32'(bus.illegal_op), 32'd0);

        // Saturate the counter.
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            step("sat_lw", mk(OP_LW, 0, 1, 5, 0), 1'b0);
            step("sat_st", mk(OP_R, FN_SLT, 2, 5, 4), 1'b0);
            step("sat_go", mk(OP_R, FN_SLT, 2, 5, 4), 1'b0);
        end
        check_val("sat_cnt", 32'(bus.bubble_cnt), 32'(CNT_MAX));

        // Asynchronous reset while a stall is being asserted.
        step("mid_lw", mk(OP_LW, 0, 1, 5, 0), 1'b0);
        @(negedge clk);
        drive(mk(OP_R, FN_ADD, 5, 2, 3), 1'b0);
        #1;
        check_val("mid_stall", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async");
        check_val("async_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("resume", mk(OP_R, FN_ADD, 5, 2, 3), 1'b0);
        check_val("resume_valid", 32'(bus.ex_valid), 32'd1);

        // Random traffic; a stalled instruction stays in ID like the real pipeline.
        cur = rand_ins();
        for (int k = 0; k < 400; k++) begin
            step("rnd", cur, 1'($urandom_range(0, 1)));
            if (!seen_stall) cur = rand_ins();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
